// File: rtl/round_robin_mux_arbiter.sv
// Round-robin arbiter for a shared 4:1 multiplexer with bounded tenure.
// All outputs are registered; a holder is preempted after MAX_HOLD cycles.
module round_robin_mux_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       address0,
    output logic       address1,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    localparam logic [3:0] HOLD = 4'(MAX_HOLD);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_owner;
    logic [1:0] w_owner_nxt;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [3:0] r_tenure;
    logic [3:0] w_tenure_nxt;
    logic [3:0] r_grant;
    logic [3:0] w_grant_nxt;
    logic [1:0] r_addr;
    logic [1:0] w_addr_nxt;
    logic       r_busy;

    logic [3:0] w_own_oh;
    logic [2:0] w_pick_ptr;
    logic [2:0] w_pick_own;

    // Returns {found, index}; examines p+1 .. p+4 and keeps the nearest hit.
    function automatic logic [2:0] rr_pick(
        input logic [1:0] p,
        input logic [3:0] r
    );
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign w_own_oh   = 4'b0001 << r_owner;
    assign w_pick_ptr = rr_pick(r_ptr, req);
    // The owner is masked so a preemption can never re-grant the holder.
    assign w_pick_own = rr_pick(r_owner, req & ~w_own_oh);

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_ptr_nxt    = r_ptr;
        w_tenure_nxt = r_tenure;
        w_grant_nxt  = r_grant;
        w_addr_nxt   = r_addr;
        unique case (r_state)
            IDLE: begin
                if (w_pick_ptr[2]) begin
                    w_state_nxt  = GRANTED;
                    w_owner_nxt  = w_pick_ptr[1:0];
                    w_ptr_nxt    = w_pick_ptr[1:0];
                    w_tenure_nxt = 4'd1;
                    w_grant_nxt  = 4'b0001 << w_pick_ptr[1:0];
                    w_addr_nxt   = w_pick_ptr[1:0];
                end
            end
            GRANTED: begin
                if (!req[r_owner] || r_tenure >= HOLD) begin
                    if (w_pick_own[2]) begin
                        w_owner_nxt  = w_pick_own[1:0];
                        w_ptr_nxt    = w_pick_own[1:0];
                        w_tenure_nxt = 4'd1;
                        w_grant_nxt  = 4'b0001 << w_pick_own[1:0];
                        w_addr_nxt   = w_pick_own[1:0];
                    end else if (!req[r_owner]) begin
                        w_state_nxt  = IDLE;
                        w_tenure_nxt = 4'd0;
                        w_grant_nxt  = 4'b0000;
                    end
                end else begin
                    w_tenure_nxt = r_tenure + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= 2'd0;
            r_ptr    <= 2'd3;
            r_tenure <= 4'd0;
            r_grant  <= 4'b0000;
            r_addr   <= 2'd0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_ptr    <= w_ptr_nxt;
            r_tenure <= w_tenure_nxt;
            r_grant  <= w_grant_nxt;
            r_addr   <= w_addr_nxt;
            r_busy   <= |w_grant_nxt;
        end
    end

    assign grant    = r_grant;
    assign address0 = r_addr[0];
    assign address1 = r_addr[1];
    assign busy     = r_busy;

endmodule
